// File: rtl/regfile.sv
// regfile: 32 x 32-bit architectural register file for the in-order pipeline.
// Two combinational read ports, one write-back port and a pending-write
// scoreboard that lets decode detect read-after-write hazards.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle write to the register being read is forwarded to
//                the read data, and that port's busy flag is suppressed.
//   undefined -> reads return the stored value; busy stays up through the
//                write cycle and drops on the following cycle.
module regfile #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  // Write-back port
  input  logic             i_we,
  input  logic [4:0]       i_waddr,
  input  logic [DW-1:0]    i_wdata,
  // Read port 1
  input  logic             i_re1,
  input  logic [4:0]       i_raddr1,
  output logic [DW-1:0]    o_rdata1,
  output logic             o_busy1,
  // Read port 2
  input  logic             i_re2,
  input  logic [4:0]       i_raddr2,
  output logic [DW-1:0]    o_rdata2,
  output logic             o_busy2,
  // Issue / scoreboard
  input  logic             i_issue,
  input  logic [4:0]       i_issue_addr,
  output logic [NREGS-1:0] o_pending
);

  logic [DW-1:0]    regs_q [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Register 0 is hardwired: writes to it never land and it is never pending.
  logic wr_valid;
  logic issue_valid;

  assign wr_valid    = i_we && (i_waddr != 5'd0);
  assign issue_valid = i_issue && (i_issue_addr != 5'd0);

  // Per-port "the write-back in this cycle targets the register being read".
  // Only meaningful with forwarding; otherwise the stored value and the
  // registered busy flag are returned unchanged.
  logic wr_hit1;
  logic wr_hit2;

`ifdef REGFILE_BYPASS_EN
  assign wr_hit1 = i_we && (i_waddr == i_raddr1);
  assign wr_hit2 = i_we && (i_waddr == i_raddr2);
`else
  assign wr_hit1 = 1'b0;
  assign wr_hit2 = 1'b0;
`endif

  // Register array: async clear, write-back on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  // Scoreboard next state: write clears, issue sets; issue applied last so a
  // same-address issue wins over the completing write (newer writer pending).
  always_comb begin
    pending_d = pending_q;
    if (wr_valid) begin
      pending_d[i_waddr] = 1'b0;
    end
    if (issue_valid) begin
      pending_d[i_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard state: async clear drops all in-flight pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Scoreboard output, held at zero for the whole time reset is asserted.
  always_comb begin
    o_pending = rst ? '0 : pending_q;
  end

  // Read port 1: zero when disabled, addressing r0, or in reset.
  always_comb begin
    o_rdata1 = '0;
    o_busy1  = 1'b0;
    if (!rst && i_re1 && (i_raddr1 != 5'd0)) begin
      if (wr_hit1) begin
        o_rdata1 = i_wdata;
        o_busy1  = 1'b0;
      end else begin
        o_rdata1 = regs_q[i_raddr1];
        o_busy1  = pending_q[i_raddr1];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    o_rdata2 = '0;
    o_busy2  = 1'b0;
    if (!rst && i_re2 && (i_raddr2 != 5'd0)) begin
      if (wr_hit2) begin
        o_rdata2 = i_wdata;
        o_busy2  = 1'b0;
      end else begin
        o_rdata2 = regs_q[i_raddr2];
        o_busy2  = pending_q[i_raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenarios plus a randomized run against a behavioural
// model of the register file and scoreboard. Honors REGFILE_BYPASS_EN.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        busy1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        busy2;
  logic        issue;
  logic [4:0]  issue_addr;
  logic [31:0] pending;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [31:0] mregs [32];
  logic [31:0] mpend;

  regfile #(.NREGS(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_we         (we),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_re1        (re1),
    .i_raddr1     (raddr1),
    .o_rdata1     (rdata1),
    .o_busy1      (busy1),
    .i_re2        (re2),
    .i_raddr2     (raddr2),
    .o_rdata2     (rdata2),
    .o_busy2      (busy2),
    .i_issue      (issue),
    .i_issue_addr (issue_addr),
    .o_pending    (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit bypass_on();
`ifdef REGFILE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (bypass_on() && we && waddr == ra) return wdata;
    return mregs[ra];
  endfunction

  function automatic logic exp_busy(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 1'b0;
    if (bypass_on() && we && waddr == ra) return 1'b0;
    return mpend[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpend = 32'h0;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    issue = 0; issue_addr = 0;
  endtask

  // Advance one clock: model takes the edge with the inputs currently driven.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (we && waddr != 0) begin
        mregs[waddr] = wdata;
        mpend[waddr] = 1'b0;
      end
      if (issue && issue_addr != 0) mpend[issue_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    tick();
    tick();
    re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd6;
    #1;
    total++;
    if (pending !== 32'h0 || rdata1 !== 32'h0 || busy1 !== 1'b0) begin
      $display("FAIL reset_hold: pending=%h rdata1=%h busy1=%b required 0/0/0",
               pending, rdata1, busy1);
    end else passed++;
    rst = 1'b0;
    idle_inputs();
    // Write r5, issue r6, then reset in the middle of a cycle.
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; issue = 1; issue_addr = 5'd6;
    tick();
    idle_inputs();
    re1 = 1; raddr1 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'hDEADBEEF || pending !== 32'h0000_0040) begin
      $display("FAIL pre_reset: rdata1=%h pending=%h required DEADBEEF/00000040",
               rdata1, pending);
    end else passed++;
    #1 rst = 1'b1;
    // Writes/issues during reset (with a would-be forwarding hit) are ignored.
    we = 1; waddr = 5'd5; wdata = 32'h1234_0000; issue = 1; issue_addr = 5'd7;
    #1;
    total++;
    if (pending !== 32'h0) begin
      $display("FAIL reset_async_pending: got %h required 00000000", pending);
    end else passed++;
    total++;
    if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin
      $display("FAIL reset_async_read: rdata1=%h busy1=%b required 0/0", rdata1, busy1);
    end else passed++;
    model_reset();
    tick();
    rst = 1'b0;
    idle_inputs();
    re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd7;
    #1;
    total++;
    if (rdata1 !== 32'h0 || pending !== 32'h0 || rdata2 !== 32'h0) begin
      $display("FAIL reset_release: rdata1=%h rdata2=%h pending=%h required all 0",
               rdata1, rdata2, pending);
    end else passed++;
    idle_inputs();
  endtask

  task automatic test_r0();
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; issue = 1; issue_addr = 5'd0;
    re1 = 1; raddr1 = 5'd0;
    #1;
    total++;
    if (rdata1 !== 32'h0 || busy1 !== 1'b0) begin
      $display("FAIL r0_same_cycle: rdata1=%h busy1=%b required 0/0", rdata1, busy1);
    end else passed++;
    tick();
    idle_inputs();
    re1 = 1; raddr1 = 5'd0;
    #1;
    total++;
    if (rdata1 !== 32'h0 || busy1 !== 1'b0 || pending[0] !== 1'b0) begin
      $display("FAIL r0_after: rdata1=%h busy1=%b pending0=%b required 0/0/0",
               rdata1, busy1, pending[0]);
    end else passed++;
    idle_inputs();
  endtask

  task automatic test_basic();
    we = 1; waddr = 5'd3; wdata = 32'h12345678;
    tick();
    idle_inputs();
    re1 = 1; raddr1 = 5'd3; re2 = 1; raddr2 = 5'd3;
    #1;
    total++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      $display("FAIL basic_both: rdata1=%h rdata2=%h required 12345678", rdata1, rdata2);
    end else passed++;
    re2 = 0;
    #1;
    total++;
    if (rdata2 !== 32'h0 || rdata1 !== 32'h12345678) begin
      $display("FAIL basic_re2_off: rdata2=%h rdata1=%h required 0/12345678",
               rdata2, rdata1);
    end else passed++;
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [31:0] want_d;
    logic        want_b;
    we = 1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    idle_inputs();
    issue = 1; issue_addr = 5'd7;
    tick();
    idle_inputs();
    we = 1; waddr = 5'd7; wdata = 32'hA5A5A5A5; re1 = 1; raddr1 = 5'd7;
    #1;
    want_d = bypass_on() ? 32'hA5A5A5A5 : 32'h11111111;
    want_b = bypass_on() ? 1'b0 : 1'b1;
    total++;
    if (rdata1 !== want_d || busy1 !== want_b) begin
      $display("FAIL bypass_same_cycle: rdata1=%h busy1=%b required %h/%b",
               rdata1, busy1, want_d, want_b);
    end else passed++;
    tick();
    idle_inputs();
    re1 = 1; raddr1 = 5'd7;
    #1;
    total++;
    if (rdata1 !== 32'hA5A5A5A5 || busy1 !== 1'b0) begin
      $display("FAIL bypass_next: rdata1=%h busy1=%b required A5A5A5A5/0", rdata1, busy1);
    end else passed++;
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    issue = 1; issue_addr = 5'd9;
    tick();
    idle_inputs();
    re1 = 1; raddr1 = 5'd9;
    #1;
    total++;
    if (busy1 !== 1'b1 || pending !== 32'h0000_0200) begin
      $display("FAIL sb_issue: busy1=%b pending=%h required 1/00000200", busy1, pending);
    end else passed++;
    tick();
    tick();
    we = 1; waddr = 5'd9; wdata = 32'h0BAD_F00D;
    #1;
    total++;
    if (busy1 !== !bypass_on()) begin
      $display("FAIL sb_write_cycle: busy1=%b required %b", busy1, !bypass_on());
    end else passed++;
    tick();
    we = 0;
    #1;
    total++;
    if (pending !== 32'h0 || busy1 !== 1'b0 || rdata1 !== 32'h0BAD_F00D) begin
      $display("FAIL sb_cleared: pending=%h busy1=%b rdata1=%h required 0/0/0BADF00D",
               pending, busy1, rdata1);
    end else passed++;
    idle_inputs();
  endtask

  task automatic test_simul();
    issue = 1; issue_addr = 5'd4;
    tick();
    we = 1; waddr = 5'd4; wdata = 32'h44; issue = 1; issue_addr = 5'd4;
    tick();
    idle_inputs();
    #1;
    total++;
    if (pending[4] !== 1'b1) begin
      $display("FAIL simul_set_wins: pending4=%b required 1", pending[4]);
    end else passed++;
    // Different addresses in one cycle act independently.
    we = 1; waddr = 5'd4; wdata = 32'h45; issue = 1; issue_addr = 5'd12;
    tick();
    idle_inputs();
    #1;
    total++;
    if (pending !== 32'h0000_1000) begin
      $display("FAIL simul_indep: pending=%h required 00001000", pending);
    end else passed++;
    we = 1; waddr = 5'd12; wdata = 32'h0;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we         = ($urandom_range(0, 2) != 0);
      waddr      = 5'($urandom_range(0, 7));
      wdata      = $urandom;
      issue      = ($urandom_range(0, 2) == 0);
      issue_addr = 5'($urandom_range(0, 7));
      re1        = ($urandom_range(0, 4) != 0);
      raddr1     = 5'($urandom_range(0, 7));
      re2        = ($urandom_range(0, 4) != 0);
      raddr2     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(0, 7));
      #1;
      total++;
      if (rdata1 !== exp_data(re1, raddr1)) begin
        $display("FAIL rand_rdata1 @%0d: got %h required %h", n, rdata1,
                 exp_data(re1, raddr1));
      end else passed++;
      total++;
      if (rdata2 !== exp_data(re2, raddr2)) begin
        $display("FAIL rand_rdata2 @%0d: got %h required %h", n, rdata2,
                 exp_data(re2, raddr2));
      end else passed++;
      total++;
      if (busy1 !== exp_busy(re1, raddr1)) begin
        $display("FAIL rand_busy1 @%0d: got %b required %b", n, busy1, exp_busy(re1, raddr1));
      end else passed++;
      total++;
      if (busy2 !== exp_busy(re2, raddr2)) begin
        $display("FAIL rand_busy2 @%0d: got %b required %b", n, busy2, exp_busy(re2, raddr2));
      end else passed++;
      total++;
      if (pending !== mpend) begin
        $display("FAIL rand_pending @%0d: got %h required %h", n, pending, mpend);
      end else passed++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_r0();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_simul();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
